// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and sizing helpers for the FIFO burst reader.
package fifo_burst_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_e;

  localparam int unsigned DATA_WIDTH_DFLT = 32;
  localparam int unsigned BYTES_PER_WORD  = DATA_WIDTH_DFLT / 8;

  // Bits needed to hold the range 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read port, address/request and data stream signals of the burst reader.
interface fifo_burst_reader_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] FifoData_in;
  logic                  FifoEmpty_in;
  logic                  FifoReadEn_out;
  logic                  Enable_in;
  logic                  BaseLoad_in;
  logic [ADDR_WIDTH-1:0] BaseAddr_in;
  logic                  Req_out;
  logic                  Gnt_in;
  logic [ADDR_WIDTH-1:0] Addr_out;
  logic [DATA_WIDTH-1:0] Data_out;
  logic                  Valid_out;
  logic                  Last_out;
  logic                  Ready_in;
  logic                  Busy_out;

  modport master (
    input  FifoData_in, FifoEmpty_in, Enable_in, BaseLoad_in, BaseAddr_in, Gnt_in, Ready_in,
    output FifoReadEn_out, Req_out, Addr_out, Data_out, Valid_out, Last_out, Busy_out
  );

  modport slave (
    output FifoData_in, FifoEmpty_in, Enable_in, BaseLoad_in, BaseAddr_in, Gnt_in, Ready_in,
    input  FifoReadEn_out, Req_out, Addr_out, Data_out, Valid_out, Last_out, Busy_out
  );
endinterface

// File: rtl/fifo_burst_reader_burst_gap_timer.sv
// Saturating empty-FIFO gap counter; o_done flags that TIMEOUT has been reached.
module burst_gap_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_done
);
  import fifo_burst_reader_pkg::*;

  localparam int unsigned CW     = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != TO_VAL)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_done = (r_cnt == TO_VAL);

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a show-ahead FIFO and emits address-tagged bursts on a valid/ready stream,
// holding one word back so Last is known before the final word is presented.
module fifo_burst_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                Clk,
  input  logic                Reset_n_in,
  fifo_burst_reader_if.master bus
);
  import fifo_burst_reader_pkg::*;

  localparam int unsigned     PW     = cnt_width(BURST_LEN);
  localparam int unsigned     BPW    = bytes_per_word(DATA_WIDTH);
  localparam logic [PW-1:0]   BL_VAL = PW'(BURST_LEN);

  state_e                r_state,  w_state_nxt;
  logic [PW-1:0]         r_popped, w_popped_nxt;
  logic [PW-1:0]         r_sent,   w_sent_nxt;
  logic                  r_hold_v, w_hold_v_nxt;
  logic [DATA_WIDTH-1:0] r_hold,   w_hold_nxt;
  logic [ADDR_WIDTH-1:0] r_addr,   w_addr_nxt;

  logic                  w_xfer_st;
  logic                  w_room;
  logic                  w_gap_done;
  logic                  w_endc;
  logic                  w_valid;
  logic                  w_last;
  logic                  w_handshake;
  logic                  w_pop;
  logic                  w_gap_inc;
  logic                  w_gap_clr;
  logic [ADDR_WIDTH-1:0] w_burst_bytes;

  // Stream qualification: a held word goes out only once its successor or the burst end is known.
  assign w_xfer_st   = (r_state == ST_XFER);
  assign w_room      = (r_popped < BL_VAL);
  assign w_endc      = !w_room | (bus.FifoEmpty_in & w_gap_done);
  assign w_valid     = w_xfer_st & r_hold_v & (!bus.FifoEmpty_in | w_endc);
  assign w_last      = w_valid & w_endc;
  assign w_handshake = w_valid & bus.Ready_in;
  assign w_pop       = w_xfer_st & !bus.FifoEmpty_in & w_room & (!r_hold_v | w_handshake);

  assign w_gap_inc   = w_xfer_st & r_hold_v & bus.FifoEmpty_in & w_room;
  assign w_gap_clr   = w_pop | (w_handshake & w_last) | !w_xfer_st;

  assign w_burst_bytes = ADDR_WIDTH'((32'(r_sent) + 32'd1) * 32'(BPW));

  burst_gap_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_gap_timer (
    .clk    (Clk),
    .rst_n  (Reset_n_in),
    .i_clr  (w_gap_clr),
    .i_inc  (w_gap_inc),
    .o_done (w_gap_done)
  );

  always_ff @(posedge Clk or negedge Reset_n_in) begin
    if (!Reset_n_in) begin
      r_state  <= ST_IDLE;
      r_popped <= '0;
      r_sent   <= '0;
      r_hold_v <= 1'b0;
      r_hold   <= '0;
      r_addr   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_popped <= w_popped_nxt;
      r_sent   <= w_sent_nxt;
      r_hold_v <= w_hold_v_nxt;
      r_hold   <= w_hold_nxt;
      r_addr   <= w_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_popped_nxt = r_popped;
    w_sent_nxt   = r_sent;
    w_hold_v_nxt = r_hold_v;
    w_hold_nxt   = r_hold;
    w_addr_nxt   = r_addr;
    case (r_state)
      ST_IDLE: begin
        if (bus.BaseLoad_in) w_addr_nxt = bus.BaseAddr_in;
        if (bus.Enable_in && !bus.FifoEmpty_in) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (bus.Gnt_in) w_state_nxt = ST_XFER;
      end
      ST_XFER: begin
        if (w_pop) begin
          w_hold_nxt   = bus.FifoData_in;
          w_hold_v_nxt = 1'b1;
          w_popped_nxt = r_popped + PW'(1);
        end
        if (w_handshake) begin
          w_sent_nxt = r_sent + PW'(1);
          // Final word accepted: advance the address past this burst and return to idle.
          if (w_last) begin
            w_addr_nxt   = r_addr + w_burst_bytes;
            w_popped_nxt = '0;
            w_sent_nxt   = '0;
            w_hold_v_nxt = 1'b0;
            w_state_nxt  = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.FifoReadEn_out = w_pop;
  assign bus.Req_out        = (r_state == ST_REQ);
  assign bus.Addr_out       = r_addr;
  assign bus.Data_out       = r_hold;
  assign bus.Valid_out      = w_valid;
  assign bus.Last_out       = w_last;
  assign bus.Busy_out       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench: queue-based FIFO plus a word-count reference model of the burst reader.
module tb_fifo_burst_reader;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned BL = 8;
  localparam int unsigned TO = 4;

  logic Clk = 1'b0;
  logic Reset_n_in;
  always #5 Clk = ~Clk;

  fifo_burst_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_burst_reader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .BURST_LEN  (BL),
    .TIMEOUT    (TO)
  ) dut (
    .Clk        (Clk),
    .Reset_n_in (Reset_n_in),
    .bus        (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [DW-1:0] fq[$];

  // Reference model: phase 0=idle 1=request 2=transfer; counts words popped/sent this burst.
  int            ph, m_popped, m_sent, m_gap;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_hold;
  logic          pend_pop;

  int ready_mode, gnt_pct, en_pct, bl_pct, push_pct, push_max;
  int cyc, last_pop_cyc, last_cyc;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    ph = 0; m_popped = 0; m_sent = 0; m_gap = 0;
    m_addr = '0; m_hold = '0; pend_pop = 1'b0;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_req"},   64'(bus.Req_out),        64'(0));
    chk({pfx, "_valid"}, 64'(bus.Valid_out),      64'(0));
    chk({pfx, "_last"},  64'(bus.Last_out),       64'(0));
    chk({pfx, "_busy"},  64'(bus.Busy_out),       64'(0));
    chk({pfx, "_rden"},  64'(bus.FifoReadEn_out), 64'(0));
    chk({pfx, "_addr"},  64'(bus.Addr_out),       64'(0));
    chk({pfx, "_data"},  64'(bus.Data_out),       64'(0));
  endtask

  task automatic set_fifo();
    bus.FifoEmpty_in = (fq.size() == 0);
    bus.FifoData_in  = (fq.size() == 0) ? 32'hDEAD_BEEF : fq[0];
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) fq.push_back($urandom());
    set_fifo();
  endtask

  // Compare DUT outputs with the model for this cycle, then advance the model across the next edge.
  task automatic check_cycle();
    logic f_empty, have, endc, valid, last, hs, pop;
    if (!Reset_n_in) begin
      chk_zero("inrst");
      model_reset();
      return;
    end
    f_empty = (fq.size() == 0);
    have    = (m_popped > m_sent);
    endc    = (m_popped == BL) || (f_empty && (m_gap == TO));
    valid   = (ph == 2) && have && (!f_empty || endc);
    last    = valid && endc;
    hs      = valid && bus.Ready_in;
    pop     = (ph == 2) && !f_empty && (m_popped < BL) && (!have || hs);

    chk("req",   64'(bus.Req_out),        64'(ph == 1));
    chk("busy",  64'(bus.Busy_out),       64'(ph != 0));
    chk("valid", 64'(bus.Valid_out),      64'(valid));
    chk("rden",  64'(bus.FifoReadEn_out), 64'(pop));
    if (valid) begin
      chk("last", 64'(bus.Last_out), 64'(last));
      chk("data", 64'(bus.Data_out), 64'(m_hold));
    end
    if (ph == 1) chk("addr", 64'(bus.Addr_out), 64'(m_addr));

    if (bus.FifoReadEn_out) last_pop_cyc = cyc;
    if (bus.Valid_out && bus.Last_out && bus.Ready_in) last_cyc = cyc;

    pend_pop = 1'b0;
    case (ph)
      0: begin
        if (bus.BaseLoad_in) m_addr = bus.BaseAddr_in;
        if (bus.Enable_in && !f_empty) ph = 1;
      end
      1: if (bus.Gnt_in) ph = 2;
      default: begin
        if (pop) begin
          m_hold = fq[0]; m_popped++; m_gap = 0; pend_pop = 1'b1;
        end else if (have && f_empty && (m_popped < BL) && (m_gap < TO)) begin
          m_gap++;
        end
        if (hs) begin
          m_sent++;
          if (last) begin
            m_addr = m_addr + AW'(m_sent * (DW / 8));
            m_popped = 0; m_sent = 0; m_gap = 0; ph = 0;
          end
        end
      end
    endcase
  endtask

  task automatic drive_random();
    if (fq.size() < 32 && $urandom_range(99) < push_pct)
      for (int i = 0; i < int'($urandom_range(push_max, 1)); i++) fq.push_back($urandom());
    case (ready_mode)
      0:       bus.Ready_in = 1'b1;
      1:       bus.Ready_in = ~bus.Ready_in;
      default: bus.Ready_in = ($urandom_range(99) < 60);
    endcase
    bus.Gnt_in      = ($urandom_range(99) < gnt_pct);
    bus.Enable_in   = ($urandom_range(99) < en_pct);
    bus.BaseLoad_in = ($urandom_range(99) < bl_pct);
    bus.BaseAddr_in = {$urandom()} & 32'hFFFF_FFFC;
  endtask

  // One clock: check at the falling edge, update stimulus just after the rising edge.
  task automatic step();
    @(negedge Clk);
    check_cycle();
    cyc++;
    @(posedge Clk);
    #1;
    if (pend_pop) void'(fq.pop_front());
    pend_pop = 1'b0;
    drive_random();
    set_fifo();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (!(ph == 0 && fq.size() == 0) && n < 500) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, 64'(ph == 0 && fq.size() == 0), 64'(1));
    step();
  endtask

  task automatic load_base(input logic [AW-1:0] a);
    bus.BaseLoad_in = 1'b1;
    bus.BaseAddr_in = a;
    step();
  endtask

  task automatic directed_knobs(input int rmode);
    ready_mode = rmode; gnt_pct = 100; en_pct = 100; bl_pct = 0; push_pct = 0; push_max = 1;
    bus.Ready_in = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    cyc = 0; last_pop_cyc = 0; last_cyc = 0;
    Reset_n_in = 1'b0;
    bus.FifoData_in = '0; bus.FifoEmpty_in = 1'b1; bus.Enable_in = 1'b0;
    bus.BaseLoad_in = 1'b0; bus.BaseAddr_in = '0; bus.Gnt_in = 1'b0; bus.Ready_in = 1'b0;
    model_reset();
    directed_knobs(0);
    step(); step();
    Reset_n_in = 1'b1;
    step();

    // Full bursts: 20 words -> 8 + 8 + 4 (timeout) from 0x1000.
    load_base(32'h1000);
    push_words(20);
    drain("full");
    chk("full_next_addr", 64'(bus.Addr_out), 64'h1050);

    // Short burst ends by timeout TIMEOUT+1 cycles after the last pop.
    load_base(32'h2000);
    push_words(3);
    drain("short");
    chk("short_latency", 64'(last_cyc - last_pop_cyc), 64'(TO + 1));
    chk("short_next_addr", 64'(bus.Addr_out), 64'h200C);

    // Backpressure with Ready toggling.
    directed_knobs(1);
    load_base(32'h3000);
    push_words(16);
    drain("bp");
    chk("bp_next_addr", 64'(bus.Addr_out), 64'h3040);

    // Mid-burst FIFO gap shorter than TIMEOUT, then refill.
    directed_knobs(0);
    load_base(32'h4000);
    push_words(4);
    n = 0;
    while (m_popped < 4 && n < 50) begin step(); n++; end
    chk("gap_reach_pop4", 64'(m_popped), 64'(4));
    step(); step(); step();
    push_words(8);
    drain("gap");
    chk("gap_next_addr", 64'(bus.Addr_out), 64'h4030);

    // Address wrap.
    load_base(32'hFFFF_FFF0);
    push_words(8);
    drain("wrap");
    chk("wrap_next_addr", 64'(bus.Addr_out), 64'h10);

    // Asynchronous reset in the middle of a transfer.
    load_base(32'h5000);
    push_words(10);
    n = 0;
    while (m_sent < 2 && n < 50) begin step(); n++; end
    chk("rst_reach_sent2", 64'(m_sent), 64'(2));
    Reset_n_in = 1'b0;
    #1;
    chk_zero("rstx");
    model_reset();
    step(); step();
    Reset_n_in = 1'b1;
    n = 0;
    while (ph != 1 && n < 20) begin step(); n++; end
    chk("rst_restart_req", 64'(bus.Req_out), 64'(1));
    chk("rst_restart_addr", 64'(bus.Addr_out), 64'(0));
    drain("rst");

    // Randomized traffic, grants, enables, backpressure and base loads.
    ready_mode = 2; gnt_pct = 70; en_pct = 80; bl_pct = 5; push_pct = 40; push_max = 2;
    for (int i = 0; i < 3000; i++) step();
    directed_knobs(0);
    drain("rand");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side consumer of the asynchronous FIFO, in the FIFO's read clock domain. It pops words from the FIFO's show-ahead read port and presents them as address-tagged bursts on a valid/ready stream towards the PCI master. A burst ends when BURST_LEN words have been sent or when the FIFO stays empty for TIMEOUT cycles mid-burst. A one-word holding register lets the block decide Last before the final word is presented.

## Interface
- DATA_WIDTH, 32: FIFO and stream word width (multiple of 8)
- ADDR_WIDTH, 32: byte-address width
- BURST_LEN, 8: maximum words per burst (≥2)
- TIMEOUT, 16: empty-FIFO cycles tolerated mid-burst before forced termination (≥1)

- Clk  in  1  single clock, connected to the FIFO read clock RClk
- Reset_n_in  in  1  asynchronous, active-low reset
- FifoData_in  in  DATA_WIDTH  FIFO Data_out; show-ahead, valid whenever FifoEmpty_in=0
- FifoEmpty_in  in  1  FIFO Empty_out
- FifoReadEn_out  out  1  FIFO ReadEn_in; combinational pop strobe
- Enable_in  in  1  permits new bursts to start
- BaseLoad_in  in  1  loads BaseAddr_in into the address counter; honoured only in IDLE
- BaseAddr_in  in  ADDR_WIDTH  base byte address
- Req_out  out  1  burst request
- Gnt_in  in  1  burst grant
- Addr_out  out  ADDR_WIDTH  burst start byte address
- Data_out  out  DATA_WIDTH  stream data (the holding register)
- Valid_out  out  1  stream valid
- Last_out  out  1  final word of the burst; qualified by Valid_out
- Ready_in  in  1  stream ready
- Busy_out  out  1  state ≠ IDLE

## Operation
- States: IDLE, REQ, XFER.
- IDLE → REQ when Enable_in=1 and FifoEmpty_in=0.
- REQ: Req_out=1, Addr_out=addr. On Gnt_in=1, go to XFER. Req_out drops in XFER.
- XFER counters:
  - popped: 0..BURST_LEN
  - sent: 0..BURST_LEN-1
  - gap: 0..TIMEOUT
- Pop, combinational: FifoReadEn_out = (XFER) & !FifoEmpty_in & (popped<BURST_LEN) & (!hold_v | (Valid_out & Ready_in)).
- A pop captures FifoData_in into the holding register at the same edge.
- endc = (popped==BURST_LEN) | (FifoEmpty_in & gap==TIMEOUT)
- Valid_out = XFER & hold_v & (!FifoEmpty_in | endc)
- Last_out = Valid_out & endc
- A word is presented only when a successor is available or the burst is known to end.
- gap: increments each XFER cycle with hold_v=1, FifoEmpty_in=1, popped<BURST_LEN. It saturates at TIMEOUT and clears on every pop.
- Transfer is Valid_out & Ready_in. On each transfer, sent increments. On the Last transfer:
  - addr += (sent+1)·DATA_WIDTH/8, modulo 2^ADDR_WIDTH (wraps silently)
  - counters clear, hold_v=0
  - state goes to IDLE
- Enable_in deasserted mid-burst has no effect; the burst completes normally.
- BaseLoad_in outside IDLE is ignored.
- Reset (asynchronous, any state):
  - state=IDLE; addr, popped, sent and gap = 0; hold_v=0
  - words already popped are discarded
  - outputs: Req_out, Valid_out, Last_out, Busy_out, FifoReadEn_out = 0; Addr_out=0; Data_out=0

## Timing
- IDLE → REQ takes 1 cycle after the non-empty condition is seen.
- Gnt_in in the same cycle Req_out rises gives XFER on the next edge.
- First pop happens in the first XFER cycle. The first Valid_out can be asserted the following cycle, at the earliest.
- Steady state: one word per cycle while the FIFO is non-empty and Ready_in=1.
- Data_out, Last_out and Addr_out stay stable while Valid_out=1 and Ready_in=0.
- Timeout path: the last word appears TIMEOUT+1 cycles after the final pop, with Last_out=1.
- Next burst: Req_out earliest 1 cycle after the Last transfer.
- FifoReadEn_out never asserts while FifoEmpty_in=1 or in IDLE/REQ.

## Structure
- Package fifo_burst_reader_pkg:
  - state enum (IDLE, REQ, XFER)
  - function computing log2-based counter widths from BURST_LEN and TIMEOUT
  - BYTES_PER_WORD = DATA_WIDTH/8
- One sub-module, burst_gap_timer: saturating counter with clear/increment inputs and a done flag at TIMEOUT.
- Everything else (FSM, hold register, counters) lives in fifo_burst_reader.

## Test plan
Parameters: DATA_WIDTH=32, BURST_LEN=8, TIMEOUT=4.
- Full burst: BaseLoad 0x1000; FIFO preloaded with 20 words; Gnt_in=1; Ready_in=1 → Addr_out 0x1000 with 8 words, Last on the 8th. Next burst at 0x1020, then a 4-word burst at 0x1040 after TIMEOUT.
- Short burst: 3 words, no more writes → Last on word 3 exactly 5 cycles after the 3rd pop; next addr = base+12.
- Backpressure: Ready_in toggles 1010… → no pop while Valid&!Ready; data order preserved; no duplicated or dropped words.
- Gap recovery: FIFO empty for 3 cycles mid-burst, then refilled → gap clears and the burst continues to 8 words; Last only on the 8th.
- Wrap: base 0xFFFF_FFF0, full burst → next burst Addr_out 0x0000_0010.
- Reset mid-XFER after 2 transfers → all outputs 0 immediately; FifoReadEn_out=0; restart from IDLE with addr=0.
